// File: rtl/ysyx_23060061_lsu_if.sv
// Bundle of the LSU's upstream, memory-port and writeback handshakes.
// master = the LSU side, slave = the pipeline/memory environment.
interface ysyx_23060061_lsu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] store_data;
    logic [3:0]       mem_op;
    logic [4:0]       rd_in;

    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [WIDTH-1:0] mem_req_addr;
    logic             mem_req_wen;
    logic [WIDTH-1:0] mem_req_wdata;
    logic [3:0]       mem_req_wstrb;
    logic             mem_resp_valid;
    logic [WIDTH-1:0] mem_resp_rdata;
    logic             mem_resp_err;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_rd;
    logic [1:0]       out_exc;

    modport master (
        input  in_valid, alu_out, store_data, mem_op, rd_in,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output out_valid, out_data, out_rd, out_exc
    );

    modport slave (
        output in_valid, alu_out, store_data, mem_op, rd_in,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  out_valid, out_data, out_rd, out_exc
    );
endinterface

// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: one instruction at a time, at most one memory request,
// load extension, and misaligned/fault/illegal-op reporting via out_exc.
module ysyx_23060061_lsu #(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    ysyx_23060061_lsu_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_LB   = 4'b0001;
    localparam logic [3:0] OP_LH   = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_LBU  = 4'b0100;
    localparam logic [3:0] OP_LHU  = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b1001;
    localparam logic [3:0] OP_SH   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_FAULT    = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic             req_valid_q, req_valid_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    logic             req_wen_q, req_wen_d;
    logic [WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]       req_wstrb_q, req_wstrb_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [1:0]       out_exc_q, out_exc_d;

    logic             legal;
    logic             misaligned;
    logic [WIDTH-1:0] st_wdata;
    logic [3:0]       st_wstrb;
    logic [15:0]      rdata_lo;
    logic [WIDTH-1:0] load_val;

    // Classify the incoming mem_op: legal code and natural alignment of the address.
    always_comb begin
        legal      = 1'b1;
        misaligned = 1'b0;
        case (bus.mem_op)
            OP_LB, OP_LBU, OP_SB: misaligned = 1'b0;
            OP_LH, OP_LHU, OP_SH: misaligned = bus.alu_out[0];
            OP_LW, OP_SW:         misaligned = |bus.alu_out[1:0];
            default:              legal      = 1'b0;
        endcase
    end

    // Lane-replicate store data and build byte enables from the low address bits.
    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        case (bus.mem_op)
            OP_SB: begin
                st_wdata = {4{bus.store_data[7:0]}};
                st_wstrb = 4'b0001 << bus.alu_out[1:0];
            end
            OP_SH: begin
                st_wdata = {2{bus.store_data[15:0]}};
                st_wstrb = 4'b0011 << bus.alu_out[1:0];
            end
            OP_SW: begin
                st_wdata = bus.store_data;
                st_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the response word and extend it.
    always_comb begin
        rdata_lo = 16'(bus.mem_resp_rdata >> {off_q, 3'b000});
        case (op_q)
            OP_LB:   load_val = {{24{rdata_lo[7]}}, rdata_lo[7:0]};
            OP_LBU:  load_val = {24'd0, rdata_lo[7:0]};
            OP_LH:   load_val = {{16{rdata_lo[15]}}, rdata_lo};
            OP_LHU:  load_val = {16'd0, rdata_lo};
            OP_LW:   load_val = bus.mem_resp_rdata;
            default: load_val = '0;
        endcase
    end

    // Next-state and next-output logic for the IDLE/REQ/WAIT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_exc_d   = out_exc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d       = bus.mem_op;
                    off_d      = bus.alu_out[1:0];
                    out_rd_d   = bus.rd_in;
                    out_data_d = '0;
                    out_exc_d  = EXC_NONE;
                    if (bus.mem_op == OP_NONE) begin
                        out_data_d  = bus.alu_out;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (!legal) begin
                        out_exc_d   = EXC_ILLEGAL;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (misaligned) begin
                        out_exc_d   = EXC_MISALIGN;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = {bus.alu_out[WIDTH-1:2], 2'b00};
                        req_wen_d   = bus.mem_op[3];
                        req_wdata_d = st_wdata;
                        req_wstrb_d = st_wstrb;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                    if (bus.mem_resp_err) begin
                        out_exc_d  = EXC_FAULT;
                        out_data_d = '0;
                    end else begin
                        out_data_d = load_val;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            off_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_exc_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_exc_q   <= out_exc_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 throughout reset and 1 as soon as it lifts.
    assign bus.in_ready      = rst_n && (state_q == IDLE);
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wen   = req_wen_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wstrb = req_wstrb_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_exc       = out_exc_q;
endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Bench for ysyx_23060061_lsu: behavioural model, directed cases, random traffic.
`timescale 1ns/1ps
module tb_ysyx_23060061_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060061_lsu_if #(.WIDTH(32)) bus ();
    ysyx_23060061_lsu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  exc;
    } res_t;

    req_t        exp_req[$];
    res_t        exp_res[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          bp_mode = 0;
    int          rdelay = 0;
    logic [31:0] resp_rdata_v = '0;
    logic        resp_err_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string got, input string want);
        checks++;
        errors++;
        $display("FAIL %s: got %s, required %s", name, got, want);
    endtask

    // Reference: what one instruction must produce, from access size and byte offset.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rdata, input logic err,
                                  output bit has_req, output req_t rq, output res_t rs);
        int     size, o;
        bit     is_load, is_store, sgn, legal;
        longint v;
        legal = 1; is_load = 0; is_store = 0; sgn = 0; size = 4;
        o = int'(a[1:0]);
        case (op)
            4'h1: begin is_load = 1; sgn = 1; size = 1; end
            4'h2: begin is_load = 1; sgn = 1; size = 2; end
            4'h3: begin is_load = 1; size = 4; end
            4'h4: begin is_load = 1; size = 1; end
            4'h5: begin is_load = 1; size = 2; end
            4'h9: begin is_store = 1; size = 1; end
            4'hA: begin is_store = 1; size = 2; end
            4'hB: begin is_store = 1; size = 4; end
            4'h0: ;
            default: legal = 0;
        endcase
        has_req = 0;
        rq = '{default: '0};
        rs = '{default: '0};
        if (op == 4'h0) rs.data = a;
        else if (!legal) rs.exc = 2'd3;
        else if (o % size != 0) rs.exc = 2'd1;
        else begin
            has_req = 1;
            rq.addr = a - 32'(o);
            rq.wen  = is_store;
            if (is_store)
                for (int i = 0; i < 4; i++) begin
                    rq.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
                    rq.wstrb[i] = (i >= o) && (i < o + size);
                end
            if (err) rs.exc = 2'd2;
            else if (is_load) begin
                v = (longint'(rdata) >> (8 * o)) & ((64'd1 << (8 * size)) - 1);
                if (sgn && v[8*size-1]) v = v - (64'd1 << (8 * size));
                rs.data = v[31:0];
            end
        end
    endfunction

    task automatic pin_load(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] exp_data);
        bit hr; req_t rq; res_t rs;
        model(op, a, 32'h0, 32'h80FF7F01, 1'b0, hr, rq, rs);
        check(name, rs.data, exp_data);
    endtask

    task automatic pin_store(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb);
        bit hr; req_t rq; res_t rs;
        model(op, a, 32'hAABBCCDD, 32'h0, 1'b0, hr, rq, rs);
        check({name, "_addr"}, rq.addr, exp_addr);
        check({name, "_wdata"}, rq.wdata, exp_wdata);
        check({name, "_wstrb"}, 32'(rq.wstrb), 32'(exp_wstrb));
        check({name, "_data"}, rs.data, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'h0);
        check({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'h0);
        check({tag, "_req_wen"}, 32'(bus.mem_req_wen), 32'h0);
        check({tag, "_req_addr"}, bus.mem_req_addr, 32'h0);
        check({tag, "_req_wdata"}, bus.mem_req_wdata, 32'h0);
        check({tag, "_req_wstrb"}, 32'(bus.mem_req_wstrb), 32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_data"}, bus.out_data, 32'h0);
        check({tag, "_out_rd"}, 32'(bus.out_rd), 32'h0);
        check({tag, "_out_exc"}, 32'(bus.out_exc), 32'h0);
    endtask

    // Issue one instruction, queue its expectations, wait for its writeback handshake.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic err, input logic [4:0] rd,
                          input int dly, input int exp_lat);
        bit hr; req_t rq; res_t rs; int target, n;
        model(op, a, sd, rdata, err, hr, rq, rs);
        rs.rd = rd;
        if (hr) exp_req.push_back(rq);
        exp_res.push_back(rs);
        resp_rdata_v = rdata;
        resp_err_v   = err;
        rdelay       = dly;
        target       = done_cnt + 1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.in_ready) flag("in_ready_wait", "in_ready=0", "in_ready=1 within 200 cycles");
        bus.in_valid   = 1'b1;
        bus.mem_op     = op;
        bus.alu_out    = a;
        bus.store_data = sd;
        bus.rd_in      = rd;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.alu_out    = $urandom;
        bus.store_data = $urandom;
        bus.mem_op     = 4'($urandom);
        bus.rd_in      = 5'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 200);
        if (!bus.out_valid) flag("out_valid_wait", "out_valid=0", "out_valid=1 within 200 cycles");
        else if (exp_lat > 0) check("latency", n, exp_lat);
        n = 0;
        while (done_cnt < target && n < 200) begin @(negedge clk); n++; end
        if (done_cnt < target) flag("out_handshake_wait", "no handshake", "handshake within 200 cycles");
    endtask

    // Memory responder: one response pulse rdelay cycles after the request handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
            @(posedge clk);
            repeat (rdelay) @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = resp_rdata_v;
            bus.mem_resp_err   = resp_err_v;
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = $urandom;
            bus.mem_resp_err   = 1'($urandom);
        end
    end

    // Ready generators: always-ready, random, or left to the directed test.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_mode == 0) begin
            bus.mem_req_ready = 1'b1;
            bus.out_ready     = 1'b1;
        end else if (bp_mode == 1) begin
            bus.mem_req_ready = 1'($urandom);
            bus.out_ready     = 1'($urandom);
        end
    end

    // Compare process: every valid request/result against the head of the expected queues.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.mem_req_valid || bus.out_valid)
                check("in_ready_busy", 32'(bus.in_ready), 32'h0);
            if (bus.mem_req_valid) begin
                if (exp_req.size() == 0) flag("unexpected_req", "mem_req_valid=1", "no request");
                else begin
                    check("req_addr", bus.mem_req_addr, exp_req[0].addr);
                    check("req_wen", 32'(bus.mem_req_wen), 32'(exp_req[0].wen));
                    check("req_wdata", bus.mem_req_wdata, exp_req[0].wdata);
                    check("req_wstrb", 32'(bus.mem_req_wstrb), 32'(exp_req[0].wstrb));
                    if (bus.mem_req_ready) void'(exp_req.pop_front());
                end
            end
            if (bus.out_valid) begin
                if (exp_res.size() == 0) flag("unexpected_out", "out_valid=1", "no result");
                else begin
                    check("out_data", bus.out_data, exp_res[0].data);
                    check("out_rd", 32'(bus.out_rd), 32'(exp_res[0].rd));
                    check("out_exc", 32'(bus.out_exc), 32'(exp_res[0].exc));
                    if (bus.out_ready) begin
                        void'(exp_res.pop_front());
                        done_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required end within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hr; req_t rq; res_t rs;
        bus.in_valid = 1'b0; bus.alu_out = '0; bus.store_data = '0; bus.mem_op = '0; bus.rd_in = '0;
        bus.mem_req_ready = 1'b1; bus.out_ready = 1'b1;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;

        // Model pinned to hand-computed values
        pin_load("pin_lb", 4'h1, 32'h103, 32'hFFFFFF80);
        pin_load("pin_lbu", 4'h4, 32'h103, 32'h00000080);
        pin_load("pin_lh", 4'h2, 32'h102, 32'hFFFF80FF);
        pin_load("pin_lhu", 4'h5, 32'h100, 32'h00007F01);
        pin_load("pin_lw", 4'h3, 32'h100, 32'h80FF7F01);
        pin_store("pin_sb", 4'h9, 32'h201, 32'h200, 32'hDDDDDDDD, 4'b0010);
        pin_store("pin_sh", 4'hA, 32'h202, 32'h200, 32'hCCDDCCDD, 4'b1100);
        pin_store("pin_sw", 4'hB, 32'h204, 32'h204, 32'hAABBCCDD, 4'b1111);
        model(4'h3, 32'h102, 32'h0, 32'h0, 1'b0, hr, rq, rs);
        check("pin_mis_exc", 32'(rs.exc), 32'd1);
        check("pin_mis_noreq", 32'(hr), 32'd0);
        model(4'h7, 32'h100, 32'h0, 32'h0, 1'b0, hr, rq, rs);
        check("pin_ill_exc", 32'(rs.exc), 32'd3);
        model(4'h3, 32'h100, 32'h0, 32'h12345678, 1'b1, hr, rq, rs);
        check("pin_err_exc", 32'(rs.exc), 32'd2);
        check("pin_err_data", rs.data, 32'h0);

        // Power-on reset
        repeat (3) begin @(negedge clk); check_zero("por"); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("por_in_ready", 32'(bus.in_ready), 32'h1);

        // Directed cases, always ready, response one cycle after request
        run_op(4'h0, 32'h12345678, 32'h0, 32'h0, 1'b0, 5'd5, 0, 1);
        run_op(4'h1, 32'h103, 32'h0, 32'h80FF7F01, 1'b0, 5'd1, 0, 3);
        run_op(4'h4, 32'h103, 32'h0, 32'h80FF7F01, 1'b0, 5'd2, 0, 3);
        run_op(4'h2, 32'h102, 32'h0, 32'h80FF7F01, 1'b0, 5'd3, 0, 3);
        run_op(4'h5, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 5'd4, 0, 3);
        run_op(4'h3, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 5'd6, 0, 3);
        run_op(4'h9, 32'h201, 32'hAABBCCDD, 32'h0, 1'b0, 5'd7, 0, 3);
        run_op(4'hA, 32'h202, 32'hAABBCCDD, 32'h0, 1'b0, 5'd8, 0, 3);
        run_op(4'hB, 32'h204, 32'hAABBCCDD, 32'h0, 1'b0, 5'd9, 0, 3);
        run_op(4'h3, 32'h102, 32'h0, 32'h0, 1'b0, 5'd10, 0, 1);
        run_op(4'h7, 32'h100, 32'h0, 32'h0, 1'b0, 5'd11, 0, 1);
        run_op(4'h3, 32'h100, 32'h0, 32'h12345678, 1'b1, 5'd12, 0, 3);

        // Back-pressure on both the request and the writeback handshakes
        @(posedge clk); #1;
        bp_mode = 2; bus.mem_req_ready = 1'b0; bus.out_ready = 1'b0;
        fork
            run_op(4'hB, 32'h300, 32'h11223344, 32'h0, 1'b0, 5'd13, 0, 0);
            begin : bp_side
                int k;
                k = 0;
                @(negedge clk);
                while (!bus.mem_req_valid && k < 50) begin @(negedge clk); k++; end
                repeat (4) begin
                    check("bp_req_valid", 32'(bus.mem_req_valid), 32'h1);
                    check("bp_req_in_ready", 32'(bus.in_ready), 32'h0);
                    @(negedge clk);
                end
                @(posedge clk); #1 bus.mem_req_ready = 1'b1;
                k = 0;
                @(negedge clk);
                while (!bus.out_valid && k < 50) begin @(negedge clk); k++; end
                repeat (3) begin
                    check("bp_out_valid", 32'(bus.out_valid), 32'h1);
                    check("bp_out_in_ready", 32'(bus.in_ready), 32'h0);
                    @(negedge clk);
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        bp_mode = 0;

        // Reset while waiting for a response; the late response must be ignored
        model(4'h3, 32'h40, 32'h0, 32'h0, 1'b0, hr, rq, rs);
        exp_req.push_back(rq);
        resp_rdata_v = 32'hDEADBEEF; resp_err_v = 1'b0; rdelay = 6;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mem_op = 4'h3; bus.alu_out = 32'h40; bus.rd_in = 5'd20;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); check_zero("rst_wait"); end
        #1 rst_n = 1'b1;
        #1 check("rst_rel_in_ready", 32'(bus.in_ready), 32'h1);
        exp_req.delete();
        exp_res.delete();
        repeat (10) begin
            @(negedge clk);
            check("stale_out_valid", 32'(bus.out_valid), 32'h0);
            check("stale_in_ready", 32'(bus.in_ready), 32'h1);
        end

        // Random traffic with random back-pressure and response delay
        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            int         sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = 4'h0; 1: op = 4'h1; 2: op = 4'h2; 3: op = 4'h3; 4: op = 4'h4;
                5: op = 4'h5; 6: op = 4'h9; 7: op = 4'hA; 8: op = 4'hB;
                default: op = 4'($urandom);
            endcase
            run_op(op, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                   5'($urandom), $urandom_range(0, 3), 0);
        end
        bp_mode = 0;
        repeat (5) @(negedge clk);
        check("drain_req", exp_req.size(), 0);
        check("drain_res", exp_res.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060061_lsu.md
# ysyx_23060061_lsu

Load/store unit directly downstream of the ALU in the execute path. It takes the ALU result as an effective address, or as a plain result for non-memory instructions, and issues at most one request on a simple valid/ready memory port. It sign/zero-extends load data and hands a result plus destination tag to writeback over a valid/ready handshake. It detects misaligned accesses and bus errors and reports them as exception codes rather than issuing or retrying.

## Interface
- WIDTH, 32, datapath width; only 32 supported (byte lanes = WIDTH/8 = 4)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  LSU can accept (high only in IDLE, out of reset)
- alu_out  in  WIDTH  effective address (mem op) or result (non-mem)
- store_data  in  WIDTH  rs2 value for stores
- mem_op  in  4  0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; all other codes illegal
- rd_in  in  5  destination register tag, passed through
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  WIDTH  lane-replicated store data
- mem_req_wstrb  out  4  byte enables (0000 for loads)
- mem_resp_valid  in  1  response valid (one cycle pulse)
- mem_resp_rdata  in  WIDTH  full word read data
- mem_resp_err  in  1  access fault, qualified by mem_resp_valid
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_data  out  WIDTH  load result / pass-through result / 0 for stores and exceptions
- out_rd  out  5  captured rd_in
- out_exc  out  2  0 none, 1 misaligned, 2 access fault, 3 illegal mem_op

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready, capture alu_out, store_data, mem_op, rd_in.
  - mem_op none: out_data=alu_out, exc=0, go to DONE.
  - Illegal mem_op: exc=3, go to DONE.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): exc=1, go to DONE. No memory request is issued.
  - Otherwise go to REQ.
- REQ
  - mem_req_valid=1. Addr, wen, wdata and wstrb stay stable until mem_req_ready.
  - On handshake, go to WAIT.
- Store encoding (o = addr[1:0])
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<o.
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<o.
  - SW: wdata=sd, wstrb=1111.
- WAIT
  - On mem_resp_valid, go to DONE.
  - If err: exc=2, out_data=0.
  - Else, for a load, select bytes by o:
    - LB/LBU: byte rdata[8o+7:8o], sign/zero-extended.
    - LH/LHU: half rdata[8o+15:8o], sign/zero-extended.
    - LW: full word.
  - Stores: out_data=0.
- DONE
  - out_valid=1. out_data, out_rd and out_exc are held until out_ready.
  - On handshake, go to IDLE.
- mem_resp_valid outside WAIT is ignored. This includes a stale response after reset.

## Timing
- Reset (rst_n low at a clock edge): state=IDLE. The following outputs are 0 and stay 0 while rst_n is low: in_ready, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb, out_valid, out_data, out_rd, out_exc.
- Reset mid-operation (REQ/WAIT/DONE) abandons the transaction with no output pulse. in_ready=1 in the first cycle after rst_n returns high.
- Non-mem/exception latency: accepted at edge N, out_valid high in cycle N+1.
- Memory latency with mem_req_ready=1 and response one cycle after request: accepted at N, req_valid in N+1, resp in N+2, out_valid in N+3.
- Back-pressure on any handshake extends the corresponding state indefinitely with outputs held. Throughput is at most one instruction per 2 cycles; there is no overlap.
- Memory must not assert mem_resp_valid in the same cycle as the request handshake.

## Test plan
- Reset: hold rst_n=0 for 3 cycles during WAIT, then release → all outputs 0 while low; in_ready=1 on the first cycle after release; a late mem_resp_valid is ignored.
- Pass-through: mem_op=0000, alu_out=0x12345678, rd=5, out_ready=1 → out_valid one cycle later with out_data=0x12345678, out_rd=5, exc=0; no mem_req_valid.
- Loads: rdata=0x80FF7F01 at word 0x100.
  - LB @0x103 → 0xFFFFFF80.
  - LBU @0x103 → 0x00000080.
  - LH @0x102 → 0xFFFF80FF.
  - LHU @0x100 → 0x00007F01.
  - LW @0x100 → 0x80FF7F01.
- Stores with store_data=0xAABBCCDD:
  - SB @0x201 → addr 0x200, wdata 0xDDDDDDDD, wstrb 0010.
  - SH @0x202 → wdata 0xCCDDCCDD, wstrb 1100.
  - SW → wstrb 1111.
  - Each: out_data=0.
- Exceptions:
  - LW @0x102 → exc=1, no request.
  - mem_op=0111 → exc=3.
  - LW with mem_resp_err=1 → exc=2, out_data=0.
- Back-pressure: hold mem_req_ready=0 for 4 cycles, then out_ready=0 for 3 cycles → request fields and output fields stay stable throughout; in_ready=0 until the output handshake completes.
